sram_array_responder: RTL and testbench
=======================================

// Module: sram_array_responder
// PURPOSE
//  Synthesizable responder for the 4Kx8 SRAM macro pin protocol (write_en, active-low sense_en, addr, din, dout).
//  Stands in for the compiled array in FPGA/RTL builds and checks initiator timing.
//  Illegal sequences are flagged, never silently absorbed.
//  Sits between the SRAM controller and its memory slot; same pin-level contract as the macro.
// PARAMETERS
//  ADDR_W   12  address width; depth = 2**ADDR_W words
//  DATA_W   8   word width
//  WR_HOLD  2   consecutive rising edges write_en must be sampled high (stable addr/din) to commit
//  RD_LAT   1   cycles from the sense edge (sense_en sampled low) to dout update; range 1..3
// PORTS
//  clk       in   1       single clock; all state on rising edge
//  resetn    in   1       asynchronous, active-low reset
//  write_en  in   1       write request, active high
//  sense_en  in   1       sense-amp enable, active LOW (high = precharge)
//  addr      in   ADDR_W  word address
//  din       in   DATA_W  write data
//  clr_err   in   1       sync pulse: clears err_flag/err_code
//  dout      out  DATA_W  read data; holds until next completed read
//  busy      out  1       high in WR or RD state
//  err_flag  out  1       sticky protocol-violation flag
//  err_code  out  3       first violation since clear: 1 short write, 2 addr/din change in write,
//                         3 write_en with sense_en low, 4 sense without precharge, 5 sense during write
// BEHAVIOUR
//  - Reset: dout=0, busy=0, err_flag=0, err_code=0, FSM=IDLE, hold/lat counters=0; array contents NOT reset.
//  - FSM IDLE->WR on write_en=1 && sense_en=1: latch addr/din, hold_cnt=1.
//    - WR: each edge with write_en=1 and addr/din == latched -> hold_cnt+1.
//    - On hold_cnt reaching WR_HOLD: commit mem[addr]<=din, go IDLE on next edge write_en=0.
//    - If write_en stays high after commit, no second commit; a new write requires write_en low for >=1 edge.
//  - WR, write_en=0 before WR_HOLD: no commit, code 1, ->IDLE.
//  - WR, addr/din change: abort, no commit, code 2, ->IDLE.
//  - WR, sense_en=0: code 5, read ignored, write continues.
//  - IDLE, write_en=1 && sense_en=0 on same edge: code 3, neither op performed.
//  - IDLE->RD on sense_en=0 && write_en=0 && precharged (sense_en high on the previous edge):
//    latch addr, lat_cnt=1; dout<=mem[addr] on the edge where lat_cnt==RD_LAT, then ->IDLE.
//    - RD_LAT=1: dout updates at the sense edge itself.
//  - Sense without precharge (sense_en low on two consecutive edges): code 4, second sense ignored.
//    - After reset, the precharge tracker reads as precharged.
//  - Inputs changing during RD after the sense edge are ignored (address already latched).
//  - Read-after-write to the same address returns new data once the commit edge has passed.
//  - err_code captures the FIRST violation only; err_flag stays set until clr_err.
//    - clr_err with a same-cycle violation: the violation wins.
//  - Address wraps naturally (ADDR_W bits); no out-of-range case.
//  - resetn low mid-write: no commit; mid-read: dout forced 0.
// CONFIGURATION
//  SRAM_PARITY_EN defined:
//    - stores an even-parity bit per word; adds ports par_err (out 1, sticky until clr_err) and
//      inj_par (in 1: flips stored parity on the next commit).
//    - Read with mismatched parity: par_err=1, dout still updated.
//  SRAM_PARITY_EN undefined: no parity storage, no par_err/inj_par ports.
// TESTING
//  1 write 0xA5 @0x123 (write_en 2 edges), precharge, sense 1 cycle -> dout=0xA5 after RD_LAT, err_flag=0
//  2 write_en high 1 edge @0x010 din 0x3C -> err_code=1, read @0x010 returns prior content (0x00 if pre-written 0x00)
//  3 write @0x200, addr changes to 0x201 on 2nd edge -> err_code=2, neither 0x200 nor 0x201 modified
//  4 sense_en low 2 consecutive edges -> err_code=4, dout from first sense only; clr_err -> err_flag=0
//  5 write_en=1 with sense_en=0 from IDLE -> err_code=3, busy stays 0, dout unchanged
//  6 100 random write/read pairs at legal timing vs scoreboard -> zero mismatches;
//    resetn low mid-write -> no commit, dout=0

Source files
------------

// File: rtl/sram_array_responder.sv
// sram_array_responder
//   Cycle-level stand-in for the 4Kx8 SRAM macro. It accepts the macro pin
//   protocol and stores data like the array does. It also polices the initiator:
//   every illegal pin sequence is reported on err_flag/err_code and is never
//   silently absorbed.
// Ports
//   clk, resetn      clock, asynchronous active-low reset
//   write_en         write request (active high), must be held WR_HOLD edges
//   sense_en         sense-amp enable, active low (high = precharge)
//   addr, din        word address, write data
//   clr_err          sync pulse clearing err_flag/err_code
//   dout             read data, holds until the next completed read
//   busy             high while in WR or RD
//   err_flag         sticky violation flag
//   err_code         first violation since the last clear:
//                      1 short write, 2 addr/din change during write,
//                      3 write_en with sense_en low, 4 sense without precharge,
//                      5 sense during write
// Build option
//   SRAM_PARITY_EN   adds a stored even-parity bit per word, plus the ports
//                    inj_par (corrupts the parity of the next commit) and
//                    par_err (sticky read parity mismatch).
module sram_array_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int WR_HOLD = 2,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              write_en,
  input  logic              sense_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
`ifdef SRAM_PARITY_EN
  input  logic              inj_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              err_flag,
  output logic [2:0]        err_code
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int HW    = $clog2(WR_HOLD+1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(WR_HOLD);
  localparam logic [1:0]    LAT_MAX  = 2'(RD_LAT);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wa_q, ra_q;
  logic [DATA_W-1:0] wd_q;
  logic [HW-1:0]     hold_cnt;
  logic [1:0]        lat_cnt;
  logic              prech;     // sense_en was high on the previous edge

  logic              commit, viol, ld_wr, hold_inc, ld_rd, rd_now, lat_inc;
  logic [2:0]        vcode;
  logic [ADDR_W-1:0] wr_a, rd_a;
  logic [DATA_W-1:0] wr_d;

  // A write may commit straight from IDLE only when WR_HOLD is 1.
  assign wr_a = (state == IDLE) ? addr : wa_q;
  assign wr_d = (state == IDLE) ? din  : wd_q;
  assign rd_a = (state == RD)   ? ra_q : addr;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_n;

  always_comb begin
    state_n  = state;
    commit   = 1'b0;
    viol     = 1'b0;
    vcode    = 3'd0;
    ld_wr    = 1'b0;
    hold_inc = 1'b0;
    ld_rd    = 1'b0;
    rd_now   = 1'b0;
    lat_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (write_en && !sense_en) begin
          viol = 1'b1; vcode = 3'd3;
        end else if (write_en) begin
          ld_wr = 1'b1;
          if (WR_HOLD == 1) commit = 1'b1;
          state_n = WR;
        end else if (!sense_en) begin
          if (prech) begin
            ld_rd = 1'b1;
            if (RD_LAT == 1) rd_now = 1'b1;
            else             state_n = RD;
          end else begin
            viol = 1'b1; vcode = 3'd4;
          end
        end
      end
      WR: begin
        if (hold_cnt == HOLD_MAX) begin
          // Already committed: wait for write_en to drop before a new write.
          if (!write_en) state_n = IDLE;
        end else if (!write_en) begin
          viol = 1'b1; vcode = 3'd1; state_n = IDLE;
        end else if (addr != wa_q || din != wd_q) begin
          viol = 1'b1; vcode = 3'd2; state_n = IDLE;
        end else begin
          hold_inc = 1'b1;
          if (hold_cnt + HW'(1) == HOLD_MAX) commit = 1'b1;
        end
        // The read request is dropped, but the write keeps going.
        if (!sense_en && !viol) begin
          viol = 1'b1; vcode = 3'd5;
        end
      end
      RD: begin
        // The address is already latched; pins are ignored until dout updates.
        lat_inc = 1'b1;
        if (lat_cnt + 2'd1 == LAT_MAX) begin
          rd_now  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wa_q     <= '0;
      wd_q     <= '0;
      ra_q     <= '0;
      hold_cnt <= '0;
      lat_cnt  <= '0;
      prech    <= 1'b1;
      dout     <= '0;
      err_flag <= 1'b0;
      err_code <= 3'd0;
    end else begin
      prech <= sense_en;
      if (ld_wr) begin
        wa_q     <= addr;
        wd_q     <= din;
        hold_cnt <= HW'(1);
      end else if (hold_inc) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      if (ld_rd) begin
        ra_q    <= addr;
        lat_cnt <= 2'd1;
      end else if (lat_inc) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
      if (rd_now) dout <= mem[rd_a];
      // A violation on the same edge as clr_err wins and is recorded as the first.
      if (viol) begin
        err_flag <= 1'b1;
        if (!err_flag || clr_err) err_code <= vcode;
      end else if (clr_err) begin
        err_flag <= 1'b0;
        err_code <= 3'd0;
      end
    end

  // The array itself is not reset, just like the macro.
  always_ff @(posedge clk)
    if (commit) mem[wr_a] <= wr_d;

`ifdef SRAM_PARITY_EN
  logic mem_par [0:DEPTH-1];
  logic inj_pend;

  always_ff @(posedge clk)
    if (commit) mem_par[wr_a] <= ^wr_d ^ (inj_pend | inj_par);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      inj_pend <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      if (commit)       inj_pend <= 1'b0;
      else if (inj_par) inj_pend <= 1'b1;
      if (rd_now && (mem_par[rd_a] != ^mem[rd_a])) par_err <= 1'b1;
      else if (clr_err)                            par_err <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_sram_array_responder.sv
module tb_sram_array_responder;
  logic        clk = 1'b0;
  logic        resetn, write_en, sense_en, clr_err;
  logic [11:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        busy, err_flag;
  logic [2:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0]  model [logic [11:0]];
  logic [7:0]  sb [$];
  logic [11:0] waddr [100];

  sram_array_responder dut (
    .clk(clk), .resetn(resetn), .write_en(write_en), .sense_en(sense_en),
    .addr(addr), .din(din), .clr_err(clr_err),
    .dout(dout), .busy(busy), .err_flag(err_flag), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    write_en = 1'b0; sense_en = 1'b1; clr_err = 1'b0; tick;
  endtask

  task automatic clear;
    clr_err = 1'b1; tick; clr_err = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d);
    addr = a; din = d; write_en = 1'b1; sense_en = 1'b1;
    tick; tick;
    write_en = 1'b0; tick;
    model[a] = d;
  endtask

  // Sense for one edge; with RD_LAT=1 dout updates on that edge.
  task automatic do_read(input string tag, input logic [11:0] a);
    logic [7:0] exp;
    sb.push_back(model.exists(a) ? model[a] : 8'h00);
    addr = a; write_en = 1'b0; sense_en = 1'b0;
    tick;
    sense_en = 1'b1;
    if (sb.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, {24'h0, dout}, {24'h0, exp});
    end
    tick;
  endtask

  initial begin
    resetn = 1'b0; write_en = 1'b0; sense_en = 1'b1; clr_err = 1'b0;
    addr = '0; din = '0;
    tick; tick;
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_flag", {31'h0, err_flag}, 32'h0);
    check("rst_code", {29'h0, err_code}, 32'h0);
    resetn = 1'b1; idle;

    // 1: legal write then read
    addr = 12'h123; din = 8'hA5; write_en = 1'b1; tick;
    check("t1_busy_wr", {31'h0, busy}, 32'h1);
    tick; write_en = 1'b0; tick;
    model[12'h123] = 8'hA5;
    check("t1_idle", {31'h0, busy}, 32'h0);
    do_read("t1_rd", 12'h123);
    check("t1_flag", {31'h0, err_flag}, 32'h0);

    // 2: short write leaves prior content
    do_write(12'h010, 8'h00);
    addr = 12'h010; din = 8'h3C; write_en = 1'b1; tick;
    write_en = 1'b0; tick;
    check("t2_code", {29'h0, err_code}, 32'h1);
    check("t2_flag", {31'h0, err_flag}, 32'h1);
    do_read("t2_rd", 12'h010);
    clear;
    check("t2_clr", {31'h0, err_flag}, 32'h0);

    // 3: address change mid-write aborts
    do_write(12'h200, 8'h11);
    do_write(12'h201, 8'h22);
    addr = 12'h200; din = 8'h77; write_en = 1'b1; tick;
    addr = 12'h201; tick;
    write_en = 1'b0; tick;
    check("t3_code", {29'h0, err_code}, 32'h2);
    do_read("t3_rd200", 12'h200);
    do_read("t3_rd201", 12'h201);
    clear;

    // 4: sense without precharge
    do_write(12'h300, 8'h5A);
    do_write(12'h301, 8'h6B);
    addr = 12'h300; sense_en = 1'b0; tick;
    check("t4_rd1", {24'h0, dout}, 32'h5A);
    addr = 12'h301; tick;
    check("t4_code", {29'h0, err_code}, 32'h4);
    check("t4_dout", {24'h0, dout}, 32'h5A);
    sense_en = 1'b1; tick;
    clear;
    check("t4_clr", {31'h0, err_flag}, 32'h0);

    // 5: write_en with sense_en low from IDLE
    addr = 12'h300; din = 8'hFF; write_en = 1'b1; sense_en = 1'b0; tick;
    check("t5_code", {29'h0, err_code}, 32'h3);
    check("t5_busy", {31'h0, busy}, 32'h0);
    check("t5_dout", {24'h0, dout}, 32'h5A);
    idle; idle;
    do_read("t5_nowr", 12'h300);
    clear;

    // sense during write: flagged but the write still commits
    addr = 12'h400; din = 8'hC3; write_en = 1'b1; sense_en = 1'b1; tick;
    sense_en = 1'b0; tick;
    write_en = 1'b0; sense_en = 1'b1; tick;
    model[12'h400] = 8'hC3;
    check("t5b_code", {29'h0, err_code}, 32'h5);
    idle;
    do_read("t5b_rd", 12'h400);
    // a later violation does not overwrite the first
    addr = 12'h401; din = 8'h01; write_en = 1'b1; tick;
    write_en = 1'b0; tick;
    check("first_only", {29'h0, err_code}, 32'h5);
    // clr_err on the same edge as a violation: the violation wins
    write_en = 1'b1; tick;
    write_en = 1'b0; clr_err = 1'b1; tick;
    clr_err = 1'b0;
    check("clr_vs_viol_flag", {31'h0, err_flag}, 32'h1);
    check("clr_vs_viol_code", {29'h0, err_code}, 32'h1);
    clear;
    check("clr_code", {29'h0, err_code}, 32'h0);

    // 6: random legal write/read pairs
    for (int i = 0; i < 100; i++) begin
      waddr[i] = 12'($urandom);
      do_write(waddr[i], 8'($urandom));
      do_read("rnd_same", waddr[i]);
      do_read("rnd_old", waddr[$urandom_range(0, i)]);
    end
    check("rnd_flag", {31'h0, err_flag}, 32'h0);

    // reset in the middle of a write: no commit, dout cleared
    do_write(12'h055, 8'h12);
    do_read("pre_rst", 12'h055);
    addr = 12'h055; din = 8'h99; write_en = 1'b1; tick;
    #2 resetn = 1'b0; #1;
    check("mid_rst_dout", {24'h0, dout}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    tick;
    write_en = 1'b0; resetn = 1'b1;
    idle;
    do_read("mid_rst_nowr", 12'h055);
    check("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
